// File: rtl/iopad_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : iopad_bank_if
//  Purpose  : Bundle of register-file, core and pad-cell signals shared
//             between the pad-bank controller and its environment.
//  Modports : slave  - the pad-bank controller (drives the pad side)
//             master - register file / core / pad model (drives the requests)
//  Signals  : rf_oen, rf_ren, rf_filt_thr, core_dout, pad_c   (master -> slave)
//             pad_i, pad_oen, pad_ren, din, rise_pulse,
//             fall_pulse, stagger_busy                       (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface iopad_bank_if #(
    parameter int NUM_PAD = 8,
    parameter int FILT_W  = 4
);
    logic [NUM_PAD-1:0] rf_oen;
    logic [NUM_PAD-1:0] rf_ren;
    logic [FILT_W-1:0]  rf_filt_thr;
    logic [NUM_PAD-1:0] core_dout;
    logic [NUM_PAD-1:0] pad_c;
    logic [NUM_PAD-1:0] pad_i;
    logic [NUM_PAD-1:0] pad_oen;
    logic [NUM_PAD-1:0] pad_ren;
    logic [NUM_PAD-1:0] din;
    logic [NUM_PAD-1:0] rise_pulse;
    logic [NUM_PAD-1:0] fall_pulse;
    logic               stagger_busy;

    modport master (
        output rf_oen, rf_ren, rf_filt_thr, core_dout, pad_c,
        input  pad_i, pad_oen, pad_ren, din, rise_pulse, fall_pulse, stagger_busy
    );

    modport slave (
        input  rf_oen, rf_ren, rf_filt_thr, core_dout, pad_c,
        output pad_i, pad_oen, pad_ren, din, rise_pulse, fall_pulse, stagger_busy
    );
endinterface
`default_nettype wire

// File: rtl/iopad_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iopad_bank_ctrl
//  Purpose  : Control bank for NUM_PAD bidirectional pads. Registers output
//             data and pull enables, staggers output-enable turn-on one pad
//             per release, and conditions each pad C input with a
//             synchroniser plus a programmable glitch filter.
//  Ports    : clk    - bank clock
//             rst_n  - asynchronous active-low reset
//             bus    - iopad_bank_if.slave (register-file, core, pad signals)
//  Options  : IOPAD_EDGE_DET_EN - when defined, registered rise/fall strobes
//             on din are generated; otherwise both strobe outputs are 0.
//  Revision : 1.0 - initial release
// ============================================================================
module iopad_bank_ctrl #(
    parameter int NUM_PAD     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int STAG_GAP    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    iopad_bank_if.slave  bus
);

    localparam int         C_GAP_W   = 4;
    localparam logic [3:0] C_GAP_VAL = C_GAP_W'(STAG_GAP);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } stag_state_t;

    // ------------------------------------------------------------------
    // Output data and pull enable: plain one-cycle registered copies
    // ------------------------------------------------------------------
    logic [NUM_PAD-1:0] r_pad_i;
    logic [NUM_PAD-1:0] r_pad_ren;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pad_i   <= '0;
            r_pad_ren <= '1;
        end else begin
            r_pad_i   <= bus.core_dout;
            r_pad_ren <= bus.rf_ren;
        end
    end

    // ------------------------------------------------------------------
    // Output-enable stagger
    // ------------------------------------------------------------------
    stag_state_t          r_state;
    stag_state_t          w_state_nxt;
    logic [C_GAP_W-1:0]   r_gap_cnt;
    logic [C_GAP_W-1:0]   w_gap_nxt;
    logic [NUM_PAD-1:0]   r_pad_oen;
    logic [NUM_PAD-1:0]   w_pend;
    logic [NUM_PAD-1:0]   w_pend_low;
    logic [NUM_PAD-1:0]   w_release;
    logic [NUM_PAD-1:0]   w_oen_nxt;

    // Pending set is rebuilt every cycle, so withdrawn requests vanish.
    assign w_pend     = ~bus.rf_oen & r_pad_oen;
    // Two's-complement trick isolates the lowest set bit.
    assign w_pend_low = w_pend & (~w_pend + NUM_PAD'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_release   = '0;
        case (r_state)
            S_IDLE: begin
                if (|w_pend) begin
                    w_release = w_pend_low;
                    // With no gap configured the FSM stays in IDLE and
                    // releases again on the following cycle.
                    if (STAG_GAP != 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = C_GAP_VAL;
                    end
                end
            end
            S_GAP: begin
                w_gap_nxt = r_gap_cnt - C_GAP_W'(1);
                if (r_gap_cnt <= C_GAP_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gap_nxt   = '0;
            end
        endcase
    end

    // Disables apply immediately in any state; the released pad always has
    // rf_oen=0, so it can never collide with a disable on the same bit.
    assign w_oen_nxt = (r_pad_oen | bus.rf_oen) & ~w_release;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_pad_oen <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_pad_oen <= w_oen_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser and glitch filter
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_PAD-1:0] r_sync;
    logic [NUM_PAD-1:0]                  w_s;
    logic [NUM_PAD-1:0]                  r_din;
    logic [NUM_PAD-1:0]                  w_flip;
    logic [FILT_W-1:0]                   r_cnt     [NUM_PAD];
    logic [FILT_W-1:0]                   w_cnt_nxt [NUM_PAD];

    assign w_s = r_sync[SYNC_STAGES-1];

    // ">=" rather than "==" so that lowering the threshold below a running
    // count still lets the next mismatch cycle flip din.
    always_comb begin
        for (int k = 0; k < NUM_PAD; k++) begin
            w_flip[k]    = (w_s[k] != r_din[k]) && (r_cnt[k] >= bus.rf_filt_thr);
            w_cnt_nxt[k] = '0;
            if ((w_s[k] != r_din[k]) && !w_flip[k]) begin
                w_cnt_nxt[k] = r_cnt[k] + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_din  <= '0;
            for (int k = 0; k < NUM_PAD; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pad_c};
            r_din  <= r_din ^ w_flip;
            for (int k = 0; k < NUM_PAD; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge strobes, registered in step with din
    // ------------------------------------------------------------------
`ifdef IOPAD_EDGE_DET_EN
    logic [NUM_PAD-1:0] r_rise;
    logic [NUM_PAD-1:0] r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_flip & w_s;
            r_fall <= w_flip & ~w_s;
        end
    end

    assign bus.rise_pulse = r_rise;
    assign bus.fall_pulse = r_fall;
`else
    assign bus.rise_pulse = '0;
    assign bus.fall_pulse = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pad_i        = r_pad_i;
    assign bus.pad_ren      = r_pad_ren;
    assign bus.pad_oen      = r_pad_oen;
    assign bus.din          = r_din;
    assign bus.stagger_busy = (r_state == S_GAP) | (|w_pend);

endmodule
`default_nettype wire

// File: tb/tb_iopad_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iopad_bank_ctrl
//  Purpose  : Directed bench for iopad_bank_ctrl. Stimulus pushes expected
//             (cycle, signal, value) entries into a scoreboard queue; an
//             independent monitor pops and compares them when due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iopad_bank_ctrl;

    localparam int NP = 8;

    localparam int SG_OEN  = 0;
    localparam int SG_REN  = 1;
    localparam int SG_PI   = 2;
    localparam int SG_DIN  = 3;
    localparam int SG_RISE = 4;
    localparam int SG_FALL = 5;
    localparam int SG_BUSY = 6;

`ifdef IOPAD_EDGE_DET_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mon_act;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    event imm_ev;

    iopad_bank_if #(.NUM_PAD(NP), .FILT_W(4)) bus ();

    iopad_bank_ctrl #(
        .NUM_PAD    (NP),
        .SYNC_STAGES(2),
        .FILT_W     (4),
        .STAG_GAP   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input int sig);
        case (sig)
            SG_OEN:  return bus.pad_oen;
            SG_REN:  return bus.pad_ren;
            SG_PI:   return bus.pad_i;
            SG_DIN:  return bus.din;
            SG_RISE: return bus.rise_pulse;
            SG_FALL: return bus.fall_pulse;
            default: return {7'd0, bus.stagger_busy};
        endcase
    endfunction

    function automatic logic [7:0] edg(input logic [7:0] v);
        return EDGE_ON ? v : 8'h00;
    endfunction

    // cycle -1 marks an immediate (unclocked) check
    function automatic void exp_at(input int c, input int sig, input logic [7:0] v,
                                   input string n);
        exp_t e;
        e.cyc  = c;
        e.sig  = sig;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endfunction

    task automatic check_now(input int sig, input logic [7:0] v, input string n);
        logic [7:0] a;
        a = sample(sig);
        checks++;
        if (a !== v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", n, cyc, a, v);
        end
    endtask

    // Monitor: compares every entry whose cycle has arrived
    always begin
        @(negedge clk or imm_ev);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                mon_act = sample(sb[i].sig);
                checks++;
                if (mon_act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %h, want %h",
                             sb[i].name, cyc, mon_act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int c;
    int w;

    initial begin
        bus.rf_oen      = 8'hFF;
        bus.rf_ren      = 8'h00;
        bus.rf_filt_thr = 4'd0;
        bus.core_dout   = 8'h00;
        bus.pad_c       = 8'h00;
        rst_n           = 1'b0;

        // Reset state
        tick(2);
        check_now(SG_OEN,  8'hFF, "rst_oen");
        check_now(SG_REN,  8'hFF, "rst_ren");
        check_now(SG_PI,   8'h00, "rst_pad_i");
        check_now(SG_DIN,  8'h00, "rst_din");
        check_now(SG_RISE, 8'h00, "rst_rise");
        check_now(SG_FALL, 8'h00, "rst_fall");
        check_now(SG_BUSY, 8'h00, "rst_busy");
        #1;

        // Reset release, registered copies of ren / dout
        rst_n = 1'b1;
        bus.core_dout = 8'hA5;
        c = cyc;
        exp_at(c,     SG_REN,  8'hFF, "ren_before_edge");
        exp_at(c + 1, SG_REN,  8'h00, "ren_after_edge");
        exp_at(c + 1, SG_OEN,  8'hFF, "oen_after_rel");
        exp_at(c + 1, SG_PI,   8'hA5, "pad_i_copy");
        exp_at(c + 1, SG_DIN,  8'h00, "din_idle");
        exp_at(c + 1, SG_BUSY, 8'h00, "busy_idle");
        exp_at(c + 3, SG_DIN,  8'h00, "din_idle2");
        tick(3);

        // Stagger release FF -> F0
        bus.rf_oen = 8'hF0;
        c = cyc;
        exp_at(c,      SG_BUSY, 8'h01, "busy_on_req");
        exp_at(c + 1,  SG_OEN,  8'hFE, "stag_bit0");
        exp_at(c + 3,  SG_OEN,  8'hFE, "stag_gap_hold");
        exp_at(c + 4,  SG_OEN,  8'hFC, "stag_bit1");
        exp_at(c + 6,  SG_OEN,  8'hFC, "stag_gap_hold2");
        exp_at(c + 7,  SG_OEN,  8'hF8, "stag_bit2");
        exp_at(c + 10, SG_OEN,  8'hF0, "stag_bit3");
        exp_at(c + 11, SG_BUSY, 8'h01, "busy_last_gap");
        exp_at(c + 12, SG_BUSY, 8'h00, "busy_fall");
        exp_at(c + 12, SG_OEN,  8'hF0, "stag_final");
        tick(14);

        // Bounded wait for the stagger to finish
        w = 0;
        while ((bus.stagger_busy !== 1'b0) && (w < 20)) begin
            tick(1);
            w++;
        end
        checks++;
        if (bus.stagger_busy !== 1'b0) begin
            errors++;
            $display("FAIL stag_wait_timeout at cycle %0d: stagger_busy still %b after %0d cycles",
                     cyc, bus.stagger_busy, w);
        end

        // Return all pads to input
        bus.rf_oen = 8'hFF;
        c = cyc;
        exp_at(c + 1, SG_OEN,  8'hFF, "disable_all");
        exp_at(c + 1, SG_BUSY, 8'h00, "busy_after_dis");
        tick(3);

        // Withdraw and disable during GAP
        bus.rf_oen = 8'hF0;
        c = cyc;
        exp_at(c + 1, SG_OEN,  8'hFE, "wd_bit0");
        tick(1);
        bus.rf_oen = 8'hFF;
        exp_at(c + 2, SG_OEN,  8'hFF, "wd_disable_in_gap");
        exp_at(c + 2, SG_BUSY, 8'h01, "wd_busy_gap");
        exp_at(c + 3, SG_BUSY, 8'h00, "wd_busy_clear");
        exp_at(c + 4, SG_OEN,  8'hFF, "wd_no_bit1");
        exp_at(c + 7, SG_OEN,  8'hFF, "wd_no_bit2");
        tick(9);

        // Glitch filter, threshold 3: 3-cycle pulse is swallowed
        bus.rf_filt_thr = 4'd3;
        tick(1);
        c = cyc;
        bus.pad_c = 8'h20;
        exp_at(c + 4, SG_DIN, 8'h00, "glitch_din_a");
        exp_at(c + 6, SG_DIN, 8'h00, "glitch_din_b");
        exp_at(c + 8, SG_DIN, 8'h00, "glitch_din_c");
        tick(3);
        bus.pad_c = 8'h00;
        tick(8);

        // 6-cycle pulse passes after 6 cycles, then falls 6 cycles later
        c = cyc;
        bus.pad_c = 8'h20;
        exp_at(c + 5,  SG_DIN,  8'h00,      "filt_din_early");
        exp_at(c + 6,  SG_DIN,  8'h20,      "filt_din_rise");
        exp_at(c + 6,  SG_RISE, edg(8'h20), "filt_rise_strobe");
        exp_at(c + 7,  SG_RISE, 8'h00,      "filt_rise_one_cyc");
        exp_at(c + 11, SG_DIN,  8'h20,      "filt_din_hold");
        exp_at(c + 12, SG_DIN,  8'h00,      "filt_din_fall");
        exp_at(c + 12, SG_FALL, edg(8'h20), "filt_fall_strobe");
        exp_at(c + 13, SG_FALL, 8'h00,      "filt_fall_one_cyc");
        tick(6);
        bus.pad_c = 8'h00;
        tick(10);

        // Threshold 0: 3-cycle latency, one strobe per edge
        bus.rf_filt_thr = 4'd0;
        tick(1);
        c = cyc;
        bus.pad_c = 8'h04;
        exp_at(c + 2,  SG_DIN,  8'h00,      "t0_din_lat");
        exp_at(c + 3,  SG_DIN,  8'h04,      "t0_din_r1");
        exp_at(c + 3,  SG_RISE, edg(8'h04), "t0_rise1");
        exp_at(c + 3,  SG_FALL, 8'h00,      "t0_nofall1");
        exp_at(c + 4,  SG_RISE, 8'h00,      "t0_rise1_end");
        exp_at(c + 6,  SG_DIN,  8'h04,      "t0_din_hold");
        exp_at(c + 7,  SG_DIN,  8'h00,      "t0_din_f1");
        exp_at(c + 7,  SG_FALL, edg(8'h04), "t0_fall1");
        exp_at(c + 8,  SG_FALL, 8'h00,      "t0_fall1_end");
        exp_at(c + 11, SG_DIN,  8'h04,      "t0_din_r2");
        exp_at(c + 11, SG_RISE, edg(8'h04), "t0_rise2");
        exp_at(c + 15, SG_DIN,  8'h00,      "t0_din_f2");
        exp_at(c + 15, SG_FALL, edg(8'h04), "t0_fall2");
        tick(4);
        bus.pad_c = 8'h00;
        tick(4);
        bus.pad_c = 8'h04;
        tick(4);
        bus.pad_c = 8'h00;
        tick(6);

        // Asynchronous reset in the middle of a stagger
        bus.pad_c  = 8'h01;
        bus.rf_oen = 8'hF0;
        c = cyc;
        exp_at(c + 1, SG_OEN, 8'hFE, "ar_bit0");
        exp_at(c + 3, SG_DIN, 8'h01, "ar_din_before");
        exp_at(c + 4, SG_OEN, 8'hFC, "ar_bit1");
        tick(5);
        rst_n = 1'b0;
        #1;
        exp_at(-1, SG_OEN, 8'hFF, "ar_oen_async");
        exp_at(-1, SG_DIN, 8'h00, "ar_din_async");
        exp_at(-1, SG_REN, 8'hFF, "ar_ren_async");
        exp_at(-1, SG_PI,  8'h00, "ar_pad_i_async");
        ->imm_ev;
        #1;
        tick(1);
        rst_n = 1'b1;
        c = cyc;
        exp_at(c,     SG_BUSY, 8'h01, "ar_busy_reeval");
        exp_at(c + 1, SG_OEN,  8'hFE, "ar_restart_bit0");
        exp_at(c + 1, SG_DIN,  8'h00, "ar_din_resync");
        exp_at(c + 3, SG_OEN,  8'hFE, "ar_gap_hold");
        exp_at(c + 3, SG_DIN,  8'h01, "ar_din_back");
        exp_at(c + 4, SG_OEN,  8'hFC, "ar_restart_bit1");
        tick(8);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_expired at cycle %0d: %0d expectations never compared",
                     cyc, sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
